// File: rtl/redmule_z_transpose.sv
// Output transposer for the RedMulE result path.
// It collects up to Depth engine result vectors, each Width lanes wide, into
// a small buffer. It then streams Width beats, and each beat carries one
// element column across the stored rows.

package redmule_z_transpose_pkg;

  typedef enum logic [1:0] {
    FP16    = 2'd0,
    FP16ALT = 2'd1,
    FP8     = 2'd2,
    FP32    = 2'd3
  } fp_format_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP16:    return 32'd16;
      FP16ALT: return 32'd16;
      FP8:     return 32'd8;
      FP32:    return 32'd32;
      default: return 32'd16;
    endcase
  endfunction

endpackage

module redmule_z_transpose
  import redmule_z_transpose_pkg::*;
#(
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned Width    = 8,
  parameter int unsigned Depth    = 4,
  localparam int unsigned BITW    = fp_width(FpFormat)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [Width*BITW-1:0]   z_i,
  input  logic                    z_valid_i,
  input  logic                    z_last_i,
  output logic                    z_ready_o,
  output logic [Depth*BITW-1:0]   data_o,
  output logic [Depth-1:0]        strb_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    busy_o
);

  localparam int unsigned WrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned RdW = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned NvW = $clog2(Depth + 1);
  localparam logic [WrW-1:0] WrMax = WrW'(Depth - 1);
  localparam logic [RdW-1:0] RdMax = RdW'(Width - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [WrW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [RdW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [NvW-1:0]        n_valid_q, n_valid_d;
  logic                  tile_last_q, tile_last_d;
  logic [Width*BITW-1:0] buf_q [Depth];
  logic [Width*BITW-1:0] buf_d [Depth];

  logic in_hs_s;
  logic out_hs_s;

  // Handshakes and status. The input side is closed for the whole reset
  // assertion. It is also closed while draining, because the buffer is single.
  assign z_ready_o = (state_q == FILL) && !rst_i;
  assign valid_o   = (state_q == DRAIN);
  assign in_hs_s   = z_valid_i && z_ready_o;
  assign out_hs_s  = valid_o && ready_i;
  assign last_o    = valid_o && (rd_cnt_q == RdMax) && tile_last_q;
  assign busy_o    = (state_q == DRAIN) || (wr_cnt_q != {WrW{1'b0}});

  // Next-state logic: fill rows, close the tile on a full buffer or z_last_i, then drain columns.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    n_valid_d   = n_valid_q;
    tile_last_d = tile_last_q;
    buf_d       = buf_q;
    if (clear_i) begin
      // Abort wins over any handshake in the same cycle; stale rows are masked by n_valid.
      state_d     = FILL;
      wr_cnt_d    = {WrW{1'b0}};
      rd_cnt_d    = {RdW{1'b0}};
      tile_last_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_hs_s) begin
            buf_d[wr_cnt_q] = z_i;
            if ((wr_cnt_q == WrMax) || z_last_i) begin
              n_valid_d   = NvW'(wr_cnt_q) + NvW'(1);
              tile_last_d = z_last_i;
              wr_cnt_d    = {WrW{1'b0}};
              state_d     = DRAIN;
            end else begin
              wr_cnt_d = wr_cnt_q + WrW'(1);
            end
          end else begin
            wr_cnt_d = wr_cnt_q;
          end
        end
        DRAIN: begin
          if (out_hs_s) begin
            if (rd_cnt_q == RdMax) begin
              rd_cnt_d = {RdW{1'b0}};
              state_d  = FILL;
            end else begin
              rd_cnt_d = rd_cnt_q + RdW'(1);
            end
          end else begin
            rd_cnt_d = rd_cnt_q;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // Transposed beat: lane d carries element rd_cnt of row d, zeroed beyond the valid rows.
  always_comb begin
    data_o = '0;
    strb_o = '0;
    if (state_q == DRAIN) begin
      for (int d = 0; d < Depth; d++) begin
        if (NvW'(d) < n_valid_q) begin
          strb_o[d]                = 1'b1;
          data_o[d*BITW +: BITW]   = buf_q[d][32'(rd_cnt_q)*BITW +: BITW];
        end else begin
          strb_o[d]                = 1'b0;
          data_o[d*BITW +: BITW]   = '0;
        end
      end
    end else begin
      data_o = '0;
      strb_o = '0;
    end
  end

  // State, counters and buffer registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      wr_cnt_q    <= {WrW{1'b0}};
      rd_cnt_q    <= {RdW{1'b0}};
      n_valid_q   <= {NvW{1'b0}};
      tile_last_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      n_valid_q   <= n_valid_d;
      tile_last_q <= tile_last_d;
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_redmule_z_transpose.sv
// Directed bench for redmule_z_transpose with D=4, W=8 and 16-bit elements.
// Inputs are driven on the falling edge. Outputs are checked on the falling
// edge, before the new inputs are driven.

module tb_redmule_z_transpose;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int BW = 16;

  logic            clk_i     = 1'b0;
  logic            rst_i     = 1'b1;
  logic            clear_i   = 1'b0;
  logic [W*BW-1:0] z_i       = '0;
  logic            z_valid_i = 1'b0;
  logic            z_last_i  = 1'b0;
  logic            ready_i   = 1'b1;
  logic            z_ready_o;
  logic [D*BW-1:0] data_o;
  logic [D-1:0]    strb_o;
  logic            valid_o;
  logic            last_o;
  logic            busy_o;

  int n_vec = 0;
  int n_err = 0;

  redmule_z_transpose #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .z_i       (z_i),
    .z_valid_i (z_valid_i),
    .z_last_i  (z_last_i),
    .z_ready_o (z_ready_o),
    .data_o    (data_o),
    .strb_o    (strb_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element k,j of a tile tagged 'base': 16'h0bkj.
  function automatic logic [15:0] elem(input int base, input int k, input int j);
    return {4'h0, 4'(base), 4'(k), 4'(j)};
  endfunction

  function automatic logic [W*BW-1:0] vec(input int base, input int k);
    logic [W*BW-1:0] v;
    v = '0;
    for (int j = 0; j < W; j++) v[j*BW +: BW] = elem(base, k, j);
    return v;
  endfunction

  task automatic push(input int base, input int k, input logic last);
    @(negedge clk_i);
    check($sformatf("zready_fill k%0d", k), z_ready_o, 1'b1);
    z_valid_i = 1'b1;
    z_i       = vec(base, k);
    z_last_i  = last;
  endtask

  task automatic check_beat(input int b, input int nv, input logic tl, input int base);
    logic [D*BW-1:0] exp_d;
    logic [D-1:0]    exp_s;
    exp_d = '0;
    exp_s = '0;
    for (int d = 0; d < nv; d++) begin
      exp_d[d*BW +: BW] = elem(base, d, b);
      exp_s[d]          = 1'b1;
    end
    check($sformatf("valid b%0d", b), valid_o, 1'b1);
    check($sformatf("zready_drain b%0d", b), z_ready_o, 1'b0);
    check($sformatf("busy b%0d", b), busy_o, 1'b1);
    check($sformatf("data b%0d", b), data_o, exp_d);
    check($sformatf("strb b%0d", b), strb_o, exp_s);
    check($sformatf("last b%0d", b), last_o, tl && (b == W-1));
  endtask

  task automatic drain(input int nv, input logic tl, input int base, input logic hold,
                       input logic [W*BW-1:0] hold_vec, input int stall_beat);
    for (int b = 0; b < W; b++) begin
      @(negedge clk_i);
      if (hold) begin
        z_valid_i = 1'b1;
        z_i       = hold_vec;
        z_last_i  = 1'b0;
      end else begin
        z_valid_i = 1'b0;
        z_last_i  = 1'b0;
      end
      if (b == stall_beat) begin
        ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check_beat(b, nv, tl, base);
          @(negedge clk_i);
        end
        ready_i = 1'b1;
      end
      check_beat(b, nv, tl, base);
    end
  endtask

  task automatic after_drain();
    @(negedge clk_i);
    check("idle valid", valid_o, 1'b0);
    check("idle data", data_o, '0);
    check("idle strb", strb_o, '0);
    check("idle last", last_o, 1'b0);
    check("idle zready", z_ready_o, 1'b1);
    check("idle busy", busy_o, 1'b0);
  endtask

  initial begin
    // Reset state while rst_i is held.
    #2;
    check("rst zready", z_ready_o, 1'b0);
    check("rst valid", valid_o, 1'b0);
    check("rst data", data_o, '0);
    check("rst strb", strb_o, '0);
    check("rst last", last_o, 1'b0);
    check("rst busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Full tile with z_last_i on the fourth vector.
    for (int k = 0; k < D; k++) push(0, k, k == D-1);
    drain(4, 1'b1, 0, 1'b0, '0, -1);
    after_drain();

    // Partial tile closed by z_last_i on the second vector.
    push(0, 0, 1'b0);
    push(0, 1, 1'b1);
    drain(2, 1'b1, 0, 1'b0, '0, -1);
    after_drain();

    // Backpressure for three cycles at beat 3.
    for (int k = 0; k < D; k++) push(0, k, k == D-1);
    drain(4, 1'b1, 0, 1'b0, '0, 3);
    after_drain();

    // Back-to-back: z_valid_i stays high, no z_last_i, so last_o never rises.
    for (int k = 0; k < D; k++) push(0, k, 1'b0);
    drain(4, 1'b0, 0, 1'b1, vec(2, 0), -1);
    after_drain();
    for (int k = 1; k < D; k++) push(2, k, 1'b0);
    drain(4, 1'b0, 2, 1'b0, '0, -1);
    after_drain();

    // Clear during beat 2, then a clean tile.
    for (int k = 0; k < D; k++) push(3, k, k == D-1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      z_valid_i = 1'b0;
      z_last_i  = 1'b0;
      check_beat(b, 4, 1'b1, 3);
    end
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("clr valid", valid_o, 1'b0);
    check("clr zready", z_ready_o, 1'b1);
    check("clr busy", busy_o, 1'b0);
    for (int k = 0; k < D; k++) push(4, k, k == D-1);
    drain(4, 1'b1, 4, 1'b0, '0, -1);
    after_drain();

    // Reset after two accepts discards the partial tile.
    push(1, 0, 1'b0);
    push(1, 1, 1'b0);
    @(negedge clk_i);
    z_valid_i = 1'b0;
    check("busy partial", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("mid rst zready", z_ready_o, 1'b0);
    check("mid rst busy", busy_o, 1'b0);
    check("mid rst valid", valid_o, 1'b0);
    check("mid rst data", data_o, '0);
    check("mid rst strb", strb_o, '0);
    check("mid rst last", last_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < D; k++) push(5, k, k == D-1);
    drain(4, 1'b1, 5, 1'b0, '0, -1);
    after_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/redmule_z_transpose.md
REDMULE_Z_TRANSPOSE -- requirements
Module: redmule_z_transpose

Interface
REQ-001 SHALL have parameter FpFormat, default FP16, element format; BITW = fp_width(FpFormat).
REQ-002 SHALL have parameter Width, default 8, engine result lanes per vector (W).
REQ-003 SHALL have parameter Depth, default 4, result vectors per tile (D, D>=2).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 clear_i  in  1  synchronous abort of current tile.
REQ-007 z_i  in  W*BITW  engine result vector; lane j at bits [j*BITW +: BITW].
REQ-008 z_valid_i  in  1  z_i valid.
REQ-009 z_last_i  in  1  z_i is final vector of the tile (qualified by z_valid_i).
REQ-010 z_ready_o  out  1  block accepts z_i.
REQ-011 data_o  out  D*BITW  transposed output beat; lane d at bits [d*BITW +: BITW].
REQ-012 strb_o  out  D  per-lane valid mask for data_o.
REQ-013 valid_o  out  1  data_o/strb_o/last_o valid.
REQ-014 ready_i  in  1  downstream accepts beat.
REQ-015 last_o  out  1  final beat of a tile terminated by z_last_i.
REQ-016 busy_o  out  1  tile in progress.

Function
REQ-017 SHALL implement two states: FILL and DRAIN; z_ready_o = 1 only in FILL (and 0 while rst_i high); valid_o = 1 only in DRAIN.
REQ-018 Input handshake SHALL occur when z_valid_i && z_ready_o; vector stored into buffer row wr_cnt, wr_cnt incremented.
REQ-019 On input handshake with wr_cnt == D-1 or z_last_i = 1: SHALL record n_valid = wr_cnt+1 and tile_last = z_last_i, go to DRAIN next cycle, reset wr_cnt to 0.
REQ-020 In DRAIN, beat rd_cnt SHALL present data_o lane d = buffer[d][rd_cnt] for d < n_valid, all-zero for d >= n_valid; strb_o[d] = (d < n_valid).
REQ-021 last_o SHALL be 1 only when valid_o, rd_cnt == W-1 and tile_last = 1.
REQ-022 Output handshake (valid_o && ready_i) SHALL increment rd_cnt; on rd_cnt == W-1 SHALL reset rd_cnt to 0 and return to FILL next cycle.
REQ-023 While valid_o = 1 and ready_i = 0, data_o, strb_o, last_o SHALL hold stable.
REQ-024 Latency: valid_o SHALL rise the cycle after the tile's final input handshake; z_ready_o SHALL rise the cycle after the final output handshake; tile throughput = n_valid + W cycles with no stalls.
REQ-025 No input SHALL be accepted during DRAIN (single buffer, no overlap).
REQ-026 busy_o SHALL equal (state == DRAIN) || (wr_cnt != 0).
REQ-027 clear_i SHALL have priority over same-cycle handshakes: next cycle state FILL, wr_cnt = rd_cnt = 0, tile_last = 0, no data stored; buffer contents need not be cleared.
REQ-028 strb_o and data_o SHALL be 0 when valid_o = 0.
REQ-029 Element values SHALL pass bit-exact; no arithmetic on data.

Reset
REQ-030 rst_i asserted SHALL immediately force state FILL, wr_cnt = 0, rd_cnt = 0, n_valid = 0, tile_last = 0, buffer all zero.
REQ-031 During/after reset: valid_o = 0, data_o = 0, strb_o = 0, last_o = 0, busy_o = 0; z_ready_o = 0 while rst_i = 1, 1 from first cycle after deassertion.
REQ-032 Reset mid-tile SHALL discard the partial tile; next accepted vector is stored at row 0.

Verification (D=4, W=8, BITW=16)
REQ-033 Full tile: push 4 vectors, lane j of vector k = 16'h00kj, last on 4th, ready_i=1 -> 8 beats, beat j data_o = {16'h003j,16'h002j,16'h001j,16'h000j}, strb_o=4'b1111, last_o only on beat 7.
REQ-034 Partial tile: z_last_i on 2nd vector -> 8 beats, strb_o=4'b0011, lanes 2-3 = 0, last_o on beat 7, z_ready_o=0 for the 8 drain cycles.
REQ-035 Backpressure: ready_i=0 for 3 cycles at beat 3 -> data_o/strb_o held at beat 3 values, beat count still 8, z_ready_o stays 0.
REQ-036 Back-to-back: z_valid_i held 1 -> 4 accepts in 4 consecutive cycles, 8 beats in next 8 cycles, next accept on cycle 13 into row 0; no tile_last -> last_o never asserted.
REQ-037 clear_i during beat 2 with ready_i=1 -> next cycle valid_o=0, z_ready_o=1, busy_o=0; following tile transposes correctly.
REQ-038 rst_i asserted after 2 accepts -> all outputs at reset values; after release, 4 new vectors produce beats with only new data, strb_o=4'b1111.
